// File: rtl/alu_defs_pkg.sv
// Definitions shared by the execute-stage arithmetic units (saturating add/sub, sequential divider).
package alu_defs_pkg;

    localparam int WIDTH = 16;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; 0x8000 maps to 0x8000, which is correct when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_div_16bit_div_step.sv
// One restoring-division step: trial subtract of |B| from the shifted partial remainder.
module div_step #(
    parameter int WIDTH = alu_defs_pkg::WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_abs_b,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_trial;

    // The shifted remainder is below 2*|B|, so the 17-bit difference sign is exact.
    assign w_trial = i_rem - {1'b0, i_abs_b};
    assign o_q_bit = ~w_trial[WIDTH];
    assign o_rem   = w_trial[WIDTH] ? i_rem : w_trial;

endmodule

// File: rtl/seq_div_16bit.sv
// Signed 16-bit restoring divider, one quotient bit per cycle, saturating on overflow/divide-by-zero.
// Optional remainder output enabled with `define DIV_REM_EN.
module seq_div_16bit #(
    parameter int WIDTH = alu_defs_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_REM_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             overflow,
    output logic             div_zero
);
    import alu_defs_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_abs_b;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic             r_ovf;
    logic             r_dz;
`ifdef DIV_REM_EN
    logic [WIDTH-1:0] r_rem_out;
`endif

    logic             w_div_zero;
    logic             w_ovf_case;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_step_rem;
    logic             w_q_bit;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
        return s ? (WIDTH'(0) - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] sat_div0(input logic sign_a);
        return sign_a ? SAT_NEG : SAT_POS;
    endfunction

    assign w_div_zero = (divisor == '0);
    assign w_ovf_case = (dividend == SAT_NEG) && (divisor == '1);
    assign w_shift    = (r_rem << 1) | (WIDTH + 1)'(r_q[WIDTH-1]);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem   (w_shift),
        .i_abs_b (r_abs_b),
        .o_rem   (w_step_rem),
        .o_q_bit (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (w_div_zero || w_ovf_case) ? DONE : ITER;
                end
            end
            ITER:    if (r_cnt == '0) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_abs_b   <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
`ifdef DIV_REM_EN
            r_rem_out <= '0;
`endif
        end else begin
            r_busy <= (r_state == ITER) || (r_state == FIX);
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem    <= '0;
                        r_q      <= abs_val(dividend);
                        r_abs_b  <= abs_val(divisor);
                        r_sign_a <= dividend[WIDTH-1];
                        r_sign_b <= divisor[WIDTH-1];
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_ovf    <= 1'b0;
                        r_dz     <= 1'b0;
                        // Special cases resolve here so the result is ready one cycle after acceptance.
                        if (w_div_zero) begin
                            r_dz   <= 1'b1;
                            r_quot <= sat_div0(dividend[WIDTH-1]);
`ifdef DIV_REM_EN
                            r_rem_out <= '0;
`endif
                        end else if (w_ovf_case) begin
                            r_ovf  <= 1'b1;
                            r_quot <= SAT_POS;
`ifdef DIV_REM_EN
                            r_rem_out <= '0;
`endif
                        end
                    end
                end
                ITER: begin
                    r_rem <= w_step_rem;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    r_quot <= neg_if(r_q, r_sign_a ^ r_sign_b);
`ifdef DIV_REM_EN
                    r_rem_out <= neg_if(r_rem[WIDTH-1:0], r_sign_a);
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quot;
    assign overflow = r_ovf;
    assign div_zero = r_dz;
`ifdef DIV_REM_EN
    assign remainder = r_rem_out;
`endif

endmodule

// File: tb/tb_seq_div_16bit.sv
// Scoreboard bench for seq_div_16bit: directed corner cases, abort/ignore behaviour, random operands.
module tb_seq_div_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic        overflow;
    logic        div_zero;
`ifdef DIV_REM_EN
    logic [15:0] remainder;
`endif

    always #5 clk = ~clk;

    seq_div_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef DIV_REM_EN
        .remainder (remainder),
`endif
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   ia;
        int   ib;
        ia    = $signed(a);
        ib    = $signed(b);
        e.q   = '0;
        e.r   = '0;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.lat = 18;
        if (ib == 0) begin
            e.dz  = 1'b1;
            e.q   = (ia < 0) ? 16'h8000 : 16'h7FFF;
            e.lat = 1;
        end else if (ia == -32768 && ib == -1) begin
            e.ovf = 1'b1;
            e.q   = 16'h7FFF;
            e.lat = 1;
        end else begin
            e.q = 16'(ia / ib);
            e.r = 16'(ia % ib);
        end
        return e;
    endfunction

    // inj_cyc > 0 pulses start with different operands that many cycles after acceptance.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int inj_cyc);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = 16'h0003;
        seen     = 1'b0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == inj_cyc) begin
                start    = 1'b1;
                dividend = 16'h0001;
                divisor  = 16'h0001;
            end else begin
                start = 1'b0;
            end
            if (cyc == 1 && sb[0].lat > 1) check("busy_early", busy, 1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("latency", cyc, e.lat);
        check("quotient", quotient, e.q);
        check("overflow", overflow, e.ovf);
        check("div_zero", div_zero, e.dz);
        check("busy_at_done", busy, 0);
`ifdef DIV_REM_EN
        check("remainder", remainder, e.r);
`endif
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("quot_hold", quotient, e.q);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_ovf", overflow, 0);
        check("rst_dz", div_zero, 0);
`ifdef DIV_REM_EN
        check("rst_rem", remainder, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_div(16'd100, 16'd7, 0);
        run_div(16'hFF9C, 16'd7, 0);
        run_div(16'd100, 16'hFFF9, 0);
        run_div(16'h8000, 16'hFFFF, 0);
        run_div(16'd5, 16'd0, 0);
        run_div(16'hFFFB, 16'd0, 0);
        run_div(16'd0, 16'd0, 0);
        run_div(16'h8000, 16'd1, 0);
        run_div(16'h7FFF, 16'h7FFF, 0);
        run_div(16'h8000, 16'h8000, 0);
        run_div(16'd100, 16'd7, 5);
        run_div(16'hFFFF, 16'd2, 17);

        // Abort a running division with reset; no done may appear.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_quot", quotient, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(16'd100, 16'd7, 0);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (i % 5 == 1) rb = {{8{rb[7]}}, rb[7:0]};
            run_div(ra, rb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
